// File: rtl/ysyx_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_ctrl_pkg
// Description : Shared FSM state encodings, halt codes and the default
//               memory-response timeout for the core control unit.
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_ctrl_pkg;

    localparam int TIMEOUT_DEFAULT = 255;
    localparam int WAIT_W          = 8;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_HALT   = 3'd6;

    localparam logic [1:0] HC_NONE    = 2'b00;
    localparam logic [1:0] HC_EBREAK  = 2'b01;
    localparam logic [1:0] HC_ILLEGAL = 2'b10;
    localparam logic [1:0] HC_TIMEOUT = 2'b11;

    // States in which the core is waiting on a memory response.
    function automatic logic is_wait_state(input logic [2:0] s);
        return (s == ST_FETCH) || (s == ST_MEM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_wait_timer
// Description : 8-bit memory-response wait counter with clear/enable and a
//               hit flag raised when the count equals TIMEOUT.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_wait_timer
    import ysyx_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_hit
);

    localparam logic [WAIT_W-1:0] c_LIMIT = TIMEOUT[WAIT_W-1:0];

    logic [WAIT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign o_hit = (r_count == c_LIMIT);

endmodule
`default_nettype wire

// File: rtl/ysyx_core_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_core_ctrl
// Description : Multi-cycle core sequencer (fetch/decode/exec/mem/writeback)
//               with memory-response timeout and sticky halt reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_core_ctrl
    import ysyx_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        ifu_req,
    input  logic        ifu_rvalid,
    output logic        inst_we,
    input  logic        dec_is_load,
    input  logic        dec_is_store,
    input  logic        dec_rf_wr_en,
    input  logic        dec_is_ebreak,
    input  logic        dec_illegal,
    output logic        lsu_req,
    output logic        lsu_we,
    input  logic        lsu_rvalid,
    output logic        pc_we,
    output logic        rf_we,
    output logic        halt,
    output logic [1:0]  halt_code,
    output logic [2:0]  state,
    output logic [31:0] retire_cnt
);

    logic [2:0]  r_state;
    logic [1:0]  r_halt_code;
    logic [31:0] r_retire_cnt;

    logic [2:0]  w_next;
    logic [1:0]  w_code_nx;
    logic        w_rvalid_sel;
    logic        w_tmr_clr;
    logic        w_tmr_en;
    logic        w_tmr_hit;

    assign w_rvalid_sel = (r_state == ST_FETCH) ? ifu_rvalid : lsu_rvalid;

    always_comb begin
        w_next    = r_state;
        w_code_nx = r_halt_code;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next = ST_FETCH;
            end
            ST_FETCH: begin
                // A response arriving on the timeout cycle still wins.
                if (ifu_rvalid) begin
                    w_next = ST_DECODE;
                end else if (w_tmr_hit) begin
                    w_next    = ST_HALT;
                    w_code_nx = HC_TIMEOUT;
                end
            end
            ST_DECODE: begin
                if (dec_is_ebreak) begin
                    w_next    = ST_HALT;
                    w_code_nx = HC_EBREAK;
                end else if (dec_illegal) begin
                    w_next    = ST_HALT;
                    w_code_nx = HC_ILLEGAL;
                end else begin
                    w_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_next = (dec_is_load || dec_is_store) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                if (lsu_rvalid) begin
                    w_next = ST_WB;
                end else if (w_tmr_hit) begin
                    w_next    = ST_HALT;
                    w_code_nx = HC_TIMEOUT;
                end
            end
            ST_WB:   w_next = ST_FETCH;
            ST_HALT: w_next = ST_HALT;
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_tmr_clr = is_wait_state(w_next) && (w_next != r_state);
    assign w_tmr_en  = is_wait_state(r_state) && !w_rvalid_sel && !w_tmr_hit;

    ysyx_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_tmr_clr),
        .i_en  (w_tmr_en),
        .o_hit (w_tmr_hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_halt_code  <= HC_NONE;
            r_retire_cnt <= '0;
        end else begin
            r_state     <= w_next;
            r_halt_code <= w_code_nx;
            if (r_state == ST_WB) begin
                r_retire_cnt <= r_retire_cnt + 32'd1;
            end
        end
    end

    // Strobes decode from the async-reset state register, so they drop as soon as rst rises.
    assign ifu_req    = (r_state == ST_FETCH);
    assign inst_we    = (r_state == ST_FETCH) && ifu_rvalid;
    assign lsu_req    = (r_state == ST_MEM);
    assign lsu_we     = (r_state == ST_MEM) && dec_is_store;
    assign pc_we      = (r_state == ST_WB);
    assign rf_we      = (r_state == ST_WB) && dec_rf_wr_en && !dec_is_store;
    assign halt       = (r_state == ST_HALT);
    assign halt_code  = r_halt_code;
    assign state      = r_state;
    assign retire_cnt = r_retire_cnt;

endmodule
`default_nettype wire
